// File: rtl/moving_stats_pkg.sv
// Shared types and default sizing for the moving-statistics pipeline.
package moving_stats_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_WINDOW     = 16;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } win_state_t;

endpackage

// File: rtl/window_ring_buffer.sv
// WINDOW x DATA_WIDTH simple dual-port RAM; synchronous read returns the old word on a collision.
module window_ring_buffer #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/moving_window_ctrl.sv
// Sliding-window sequencer: turns each accepted sample into an (incoming, outgoing) pair and
// unwinds the window oldest-first on flush.
module moving_window_ctrl
    import moving_stats_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned WINDOW     = DEFAULT_WINDOW,
    localparam int unsigned ADDR_W     = $clog2(WINDOW)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_sample_valid,
    input  logic [DATA_WIDTH-1:0] i_sample_data,
    output logic                  o_sample_ready,
    input  logic                  i_flush,
    output logic                  o_stats_valid,
    output logic [DATA_WIDTH-1:0] o_incoming_data,
    output logic [DATA_WIDTH-1:0] o_outgoing_data,
    input  logic                  i_stats_ready,
    output logic [ADDR_W:0]       o_fill_count,
    output logic                  o_window_full,
    output logic                  o_flush_done
);

    localparam logic [ADDR_W:0] WINDOW_CNT = (ADDR_W+1)'(WINDOW);

    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
        $error("moving_window_ctrl: WINDOW must be a power of 2 and >= 2");
    end

    win_state_t            state_q, state_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] incoming_q, incoming_d;
    logic                  out_zero_q, out_zero_d;
    logic                  full_q, full_d;
    logic                  done_q, done_d;

    logic                  out_free;
    logic                  accept;
    logic                  issue;
    logic                  flush_req;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    window_ring_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WINDOW)
    ) u_ring (
        .clk     (i_clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q),
        .wr_data (i_sample_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        incoming_d   = incoming_q;
        out_zero_d   = out_zero_q;
        done_d       = 1'b0;

        out_free       = !valid_q || i_stats_ready;
        o_sample_ready = (state_q != ST_FLUSH) && !flush_pend_q && out_free;
        accept         = i_sample_valid && o_sample_ready;
        flush_req      = flush_pend_q || (i_flush && state_q != ST_FLUSH);
        issue          = (state_q == ST_FLUSH) && (count_q != '0) && out_free;
        rd_en          = accept || issue;
        // While flushing wr_ptr is frozen, so wr_ptr - count walks forward as count drains.
        rd_addr        = accept ? wr_ptr_q : ADDR_W'(wr_ptr_q - ADDR_W'(count_q));

        if (valid_q && i_stats_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            valid_d    = 1'b1;
            incoming_d = i_sample_data;
            out_zero_d = (count_q != WINDOW_CNT);
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            if (count_q != WINDOW_CNT) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end
            if (count_d == WINDOW_CNT) begin
                state_d = ST_RUN;
            end
        end

        if (issue) begin
            valid_d    = 1'b1;
            incoming_d = '0;
            out_zero_d = 1'b0;
            count_d    = count_q - (ADDR_W+1)'(1);
        end

        if (state_q == ST_FLUSH && count_q == '0) begin
            state_d = ST_FILL;
            done_d  = 1'b1;
        end

        // A sample accepted alongside the request is already counted in count_d.
        if (state_q != ST_FLUSH && flush_req) begin
            if (out_free) begin
                flush_pend_d = 1'b0;
                if (count_d == '0) begin
                    state_d = ST_FILL;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end else begin
                flush_pend_d = 1'b1;
            end
        end

        full_d = (count_d == WINDOW_CNT);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            incoming_q   <= '0;
            out_zero_q   <= 1'b1;
            full_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            incoming_q   <= incoming_d;
            out_zero_q   <= out_zero_d;
            full_q       <= full_d;
            done_q       <= done_d;
        end
    end

    assign o_stats_valid   = valid_q;
    assign o_incoming_data = incoming_q;
    assign o_outgoing_data = out_zero_q ? '0 : rd_data;
    assign o_fill_count    = count_q;
    assign o_window_full   = full_q;
    assign o_flush_done    = done_q;

endmodule

// File: tb/tb_moving_window_ctrl.sv
// Bench for moving_window_ctrl (WINDOW=4): directed scenarios plus random traffic against a queue-based window model.
module tb_moving_window_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned WIN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_sample_valid = 1'b0;
    logic [DW-1:0] i_sample_data = '0;
    logic          o_sample_ready;
    logic          i_flush = 1'b0;
    logic          o_stats_valid;
    logic [DW-1:0] o_incoming_data;
    logic [DW-1:0] o_outgoing_data;
    logic          i_stats_ready = 1'b1;
    logic [2:0]    o_fill_count;
    logic          o_window_full;
    logic          o_flush_done;

    moving_window_ctrl #(.DATA_WIDTH(DW), .WINDOW(WIN)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_sample_valid  (i_sample_valid),
        .i_sample_data   (i_sample_data),
        .o_sample_ready  (o_sample_ready),
        .i_flush         (i_flush),
        .o_stats_valid   (o_stats_valid),
        .o_incoming_data (o_incoming_data),
        .o_outgoing_data (o_outgoing_data),
        .i_stats_ready   (i_stats_ready),
        .o_fill_count    (o_fill_count),
        .o_window_full   (o_window_full),
        .o_flush_done    (o_flush_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: window contents oldest-first, expected pairs in issue order.
    logic [DW-1:0] window_q[$];
    logic [63:0]   exp_q[$];
    logic [63:0]   log_q[$];
    bit            flushing;
    bit            empty_done_due;
    bit            exp_valid_next;
    bit            stalled;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        window_q.delete();
        exp_q.delete();
        flushing       = 0;
        empty_done_due = 0;
        exp_valid_next = 0;
        stalled        = 0;
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (empty_done_due) begin
                chk("empty_flush_done", 64'(o_flush_done), 64'd1);
                empty_done_due = 0;
            end
            if (o_flush_done) begin
                chk("done_while_flushing", 64'(flushing), 64'd1);
                flushing = 0;
            end
            if (!flushing) begin
                chk("fill_count", 64'(o_fill_count), 64'(window_q.size()));
                chk("window_full", 64'(o_window_full), 64'(window_q.size() == WIN));
            end
            chk("sample_ready", 64'(o_sample_ready),
                64'(!flushing && (!o_stats_valid || i_stats_ready)));
            if (exp_valid_next) chk("latency1_valid", 64'(o_stats_valid), 64'd1);
            if (stalled)        chk("stall_hold_valid", 64'(o_stats_valid), 64'd1);
            if (o_stats_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", {o_incoming_data, o_outgoing_data}, 64'hx);
                end else begin
                    chk("pair", {o_incoming_data, o_outgoing_data}, exp_q[0]);
                    if (i_stats_ready) begin
                        log_q.push_back({o_incoming_data, o_outgoing_data});
                        void'(exp_q.pop_front());
                    end
                end
            end
            exp_valid_next = 0;
            stalled        = o_stats_valid && !i_stats_ready;
            if (i_sample_valid && o_sample_ready) begin
                logic [DW-1:0] leaving;
                leaving = (window_q.size() == WIN) ? window_q.pop_front() : '0;
                window_q.push_back(i_sample_data);
                exp_q.push_back({i_sample_data, leaving});
                exp_valid_next = 1;
            end
            if (i_flush && !flushing) begin
                if (window_q.size() == 0 && (!o_stats_valid || i_stats_ready)) empty_done_due = 1;
                foreach (window_q[k]) exp_q.push_back({32'd0, window_q[k]});
                window_q.delete();
                flushing = 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        i_sample_valid = 1'b1;
        i_sample_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_sample_ready) begin
                @(posedge clk);
                #1;
                i_sample_valid = 1'b0;
                return;
            end
        end
        chk("push_timeout", 64'd0, 64'd1);
        i_sample_valid = 1'b0;
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        cyc(1);
        i_flush = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_flush_done) begin
                cyc(1);
                return;
            end
        end
        chk("flush_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_log(input int cnt);
        for (int n = 0; n < 200; n++) begin
            if (log_q.size() >= cnt) return;
            @(negedge clk);
        end
        chk("log_timeout", 64'(log_q.size()), 64'(cnt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_valid", 64'(o_stats_valid), 64'd0);
        chk("rst_incoming", 64'(o_incoming_data), 64'd0);
        chk("rst_outgoing", 64'(o_outgoing_data), 64'd0);
        chk("rst_count", 64'(o_fill_count), 64'd0);
        chk("rst_full", 64'(o_window_full), 64'd0);
        chk("rst_done", 64'(o_flush_done), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        log_q.delete();
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] lit1 [5];
        logic [63:0] lit4 [5];
        lit1 = '{{32'd1, 32'd0}, {32'd2, 32'd0}, {32'd3, 32'd0}, {32'd4, 32'd0}, {32'd5, 32'd1}};
        lit4 = '{{32'd0, 32'd3}, {32'd0, 32'd4}, {32'd0, 32'd5}, {32'd0, 32'd6}, {32'd7, 32'd0}};
        model_clear();
        cyc(1);
        do_reset();

        // Fill, then the first wrap-around.
        for (int v = 1; v <= 4; v++) push(DW'(v));
        wait_log(4);
        cyc(1);
        chk("t1_count", 64'(o_fill_count), 64'd4);
        chk("t1_full", 64'(o_window_full), 64'd1);
        push(32'd5);
        wait_log(5);
        for (int k = 0; k < 5; k++) chk($sformatf("t1_pair%0d", k), log_q[k], lit1[k]);

        // Back-to-back wrap.
        do_reset();
        for (int v = 1; v <= 10; v++) push(DW'(v));
        wait_log(10);
        chk("t2_pair10", log_q[9], {32'd10, 32'd6});
        cyc(1);
        chk("t2_count", 64'(o_fill_count), 64'd4);

        // Backpressure holds the pair and blocks new samples.
        do_reset();
        i_stats_ready = 1'b0;
        push(32'd1);
        i_sample_valid = 1'b1;
        i_sample_data  = 32'd2;
        repeat (3) begin
            @(negedge clk);
            chk("t3_ready_low", 64'(o_sample_ready), 64'd0);
            chk("t3_hold", {31'd0, o_stats_valid, o_incoming_data}, {31'd0, 1'b1, 32'd1});
        end
        @(posedge clk);
        #1;
        i_stats_ready = 1'b1;
        push(32'd2);
        wait_log(2);
        chk("t3_second", log_q[1], {32'd2, 32'd0});

        // Flush drains oldest-first, then refill starts from zero.
        do_reset();
        for (int v = 1; v <= 6; v++) push(DW'(v));
        wait_log(6);
        log_q.delete();
        do_flush();
        wait_done();
        chk("t4_count0", 64'(o_fill_count), 64'd0);
        push(32'd7);
        wait_log(5);
        for (int k = 0; k < 5; k++) chk($sformatf("t4_pair%0d", k), log_q[k], lit4[k]);

        // Flush with a same-cycle sample, then an empty flush.
        cyc(2);
        log_q.delete();
        i_sample_valid = 1'b1;
        i_sample_data  = 32'd8;
        i_flush        = 1'b1;
        cyc(1);
        i_sample_valid = 1'b0;
        i_flush        = 1'b0;
        wait_done();
        wait_log(3);
        chk("t5_pair0", log_q[0], {32'd8, 32'd0});
        chk("t5_pair1", log_q[1], {32'd0, 32'd7});
        chk("t5_pair2", log_q[2], {32'd0, 32'd8});
        cyc(2);
        do_flush();
        @(negedge clk);
        chk("t5_empty_done", 64'(o_flush_done), 64'd1);
        chk("t5_empty_novalid", 64'(o_stats_valid), 64'd0);
        cyc(2);

        // Reset in the middle of a flush.
        do_reset();
        for (int v = 1; v <= 4; v++) push(DW'(v));
        do_flush();
        cyc(2);
        do_reset();
        push(32'd9);
        wait_log(1);
        chk("t6_pair", log_q[0], {32'd9, 32'd0});
        cyc(1);
        chk("t6_count", 64'(o_fill_count), 64'd1);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_sample_valid = ($urandom_range(0, 99) < 60);
            i_sample_data  = $urandom;
            i_stats_ready  = ($urandom_range(0, 99) < 75);
            i_flush        = ($urandom_range(0, 99) < 3);
            cyc(1);
        end
        i_sample_valid = 1'b0;
        i_flush        = 1'b0;
        i_stats_ready  = 1'b1;
        cyc(40);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
